// File: rtl/pll_ramp_sequencer_if.sv
// Signal bundle between the ramp sequencer, its software requester, the PLL
// config arbiter and the PLL lock indicator. slave is the sequencer's view.
interface pll_ramp_sequencer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_cfg_i;
  logic [31:0] cur_cfg_i;
  logic        abort_i;
  logic [31:0] cfg_o;
  logic        cfg_valid_o;
  logic        cfg_ready_i;
  logic        pll_lock_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  step_cnt_o;

  modport slave (
    input  req_valid_i, req_cfg_i, cur_cfg_i, abort_i, cfg_ready_i, pll_lock_i,
    output req_ready_o, cfg_o, cfg_valid_o, busy_o, done_o, err_o, step_cnt_o
  );

  modport master (
    output req_valid_i, req_cfg_i, cur_cfg_i, abort_i, cfg_ready_i, pll_lock_i,
    input  req_ready_o, cfg_o, cfg_valid_o, busy_o, done_o, err_o, step_cnt_o
  );
endinterface

// File: rtl/pll_ramp_sequencer.sv
// Walks the PLL feedback divider towards a target in STEP-sized words, waiting
// a settle time and then for lock between words.
module pll_ramp_sequencer #(
  parameter int STEP          = 8,
  parameter int SETTLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input logic               clk,
  input logic               rst,
  pll_ramp_sequencer_if.slave bus
);

  generate
    if (STEP < 1 || STEP > 4095) begin : g_bad_step
      $error("pll_ramp_sequencer: STEP must be in 1..4095");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("pll_ramp_sequencer: SETTLE_CYCLES must be at least 1");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
      $error("pll_ramp_sequencer: LOCK_TIMEOUT must be at least 1");
    end
  endgenerate

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [11:0]   STEP_W       = 12'(STEP);
  localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT_LOCK, DONE, ERROR} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   tgt_reg, tgt_next;
  logic [11:0]   cur_reg, cur_next;
  logic [31:0]   cfg_reg, cfg_next;
  logic          cfg_valid_reg, cfg_valid_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [7:0]    step_cnt_reg, step_cnt_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic [TW-1:0] timeout_reg, timeout_next;
  logic          abort_reg, abort_next;
  logic [1:0]    sync_reg;

  logic          accept, handshake, lock_sync, at_target;
  logic [31:0]   src_tgt, issue_word;
  logic [11:0]   src_cur;

  // Clamping to the target whenever it is within one step keeps nxt from wrapping.
  function automatic logic [11:0] step_fbdiv(input logic [11:0] cur, input logic [11:0] tgt);
    logic [11:0] res;
    res = tgt;
    if (tgt > cur) begin
      if (tgt - cur > STEP_W) res = cur + STEP_W;
    end else if (tgt < cur) begin
      if (cur - tgt > STEP_W) res = cur - STEP_W;
    end
    return res;
  endfunction

  assign accept     = bus.req_valid_i & (state_reg == IDLE);
  assign handshake  = cfg_valid_reg & bus.cfg_ready_i;
  assign lock_sync  = sync_reg[1];
  assign at_target  = (cur_reg == tgt_reg[27:16]);
  // In IDLE the first word is built straight from the request being accepted.
  assign src_tgt    = (state_reg == IDLE) ? bus.req_cfg_i : tgt_reg;
  assign src_cur    = (state_reg == IDLE) ? bus.cur_cfg_i[27:16] : cur_reg;
  assign issue_word = {src_tgt[31:28], step_fbdiv(src_cur, src_tgt[27:16]), src_tgt[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (accept) state_next = ISSUE;
      ISSUE:     if (handshake) state_next = (abort_reg | bus.abort_i) ? IDLE : SETTLE;
      SETTLE: begin
        if (bus.abort_i)           state_next = IDLE;
        else if (settle_reg == '0) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (bus.abort_i)            state_next = IDLE;
        else if (lock_sync)         state_next = at_target ? DONE : ISSUE;
        else if (timeout_reg == '0) state_next = ERROR;
      end
      DONE:      state_next = IDLE;
      ERROR:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    tgt_next       = tgt_reg;
    cur_next       = cur_reg;
    cfg_next       = cfg_reg;
    cfg_valid_next = cfg_valid_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    step_cnt_next  = step_cnt_reg;
    settle_next    = settle_reg;
    timeout_next   = timeout_reg;
    abort_next     = abort_reg;
    case (state_reg)
      IDLE: if (accept) begin
        tgt_next       = bus.req_cfg_i;
        cur_next       = bus.cur_cfg_i[27:16];
        cfg_next       = issue_word;
        cfg_valid_next = 1'b1;
        err_next       = 1'b0;
        step_cnt_next  = '0;
        abort_next     = 1'b0;
      end
      ISSUE: begin
        // An abort here cannot drop valid; it is remembered until the word goes out.
        if (bus.abort_i) abort_next = 1'b1;
        if (handshake) begin
          cfg_valid_next = 1'b0;
          cur_next       = cfg_reg[27:16];
          step_cnt_next  = (step_cnt_reg == 8'hFF) ? 8'hFF : step_cnt_reg + 8'd1;
          settle_next    = SETTLE_LOAD;
          abort_next     = 1'b0;
        end
      end
      SETTLE: if (!bus.abort_i) begin
        if (settle_reg == '0) timeout_next = TIMEOUT_LOAD;
        else                  settle_next  = settle_reg - SW'(1);
      end
      WAIT_LOCK: if (!bus.abort_i) begin
        if (lock_sync) begin
          if (at_target) begin
            done_next = 1'b1;
          end else begin
            cfg_next       = issue_word;
            cfg_valid_next = 1'b1;
          end
        end else if (timeout_reg != '0) begin
          timeout_next = timeout_reg - TW'(1);
        end
      end
      ERROR:   err_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_reg       <= '0;
      cur_reg       <= '0;
      cfg_reg       <= '0;
      cfg_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      step_cnt_reg  <= '0;
      settle_reg    <= '0;
      timeout_reg   <= '0;
      abort_reg     <= 1'b0;
      sync_reg      <= '0;
    end else begin
      tgt_reg       <= tgt_next;
      cur_reg       <= cur_next;
      cfg_reg       <= cfg_next;
      cfg_valid_reg <= cfg_valid_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      step_cnt_reg  <= step_cnt_next;
      settle_reg    <= settle_next;
      timeout_reg   <= timeout_next;
      abort_reg     <= abort_next;
      sync_reg      <= {sync_reg[0], bus.pll_lock_i};
    end
  end

  assign bus.req_ready_o = (state_reg == IDLE);
  assign bus.busy_o      = (state_reg != IDLE);
  assign bus.cfg_o       = cfg_reg;
  assign bus.cfg_valid_o = cfg_valid_reg;
  assign bus.done_o      = done_reg;
  assign bus.err_o       = err_reg;
  assign bus.step_cnt_o  = step_cnt_reg;

endmodule

// File: tb/tb_pll_ramp_sequencer.sv
// Directed bench for pll_ramp_sequencer: ramps up/down, equal target, lock
// timeout, aborts and asynchronous reset, with an automatic lock/ready model.
module tb_pll_ramp_sequencer;
  localparam int STEP     = 8;
  localparam int SETTLE   = 4;
  localparam int TIMEOUT  = 16;
  localparam int LOCK_DLY = 10;
  localparam int STALL    = 5;

  localparam logic [31:0] UP_TGT = {4'hA, 12'd120, 16'h1234};
  localparam logic [31:0] EQ_TGT = {4'h5, 12'd64,  16'h2A73};
  localparam logic [31:0] DN_TGT = {4'h3, 12'd40,  16'h0F21};
  localparam logic [31:0] TO_TGT = {4'h7, 12'd200, 16'h4411};
  localparam logic [31:0] RS_TGT = {4'h9, 12'd290, 16'h6C35};

  logic clk;
  logic rst;
  pll_ramp_sequencer_if bus ();

  pll_ramp_sequencer #(
    .STEP(STEP), .SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          done_cnt = 0;
  int          lock_cnt = 0;
  int          stall_cnt = 0;
  bit          hs_flag = 0;
  bit          lock_auto = 1;
  bit          stall_mode = 0;
  logic        prev_stall = 0;
  logic [31:0] prev_word = '0;
  logic [31:0] words_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Observer: samples outputs mid-cycle, logs each handshaken word.
  always @(negedge clk) begin
    hs_flag = bus.cfg_valid_o & bus.cfg_ready_i;
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.cfg_valid_o), 32'd1);
      chk("hold_cfg", bus.cfg_o, prev_word);
    end
    prev_stall = bus.cfg_valid_o & ~bus.cfg_ready_i;
    prev_word  = bus.cfg_o;
    if (hs_flag) begin
      words_q.push_back(bus.cfg_o);
      hs_cyc = cyc;
      $display("cycle %0d: word %0d cfg=%08h fbdiv=%0d", cyc, words_q.size(), bus.cfg_o, bus.cfg_o[27:16]);
    end
    if (bus.done_o) done_cnt++;
  end

  // PLL/arbiter model: lock drops on each word and returns LOCK_DLY cycles later.
  always @(posedge clk) begin
    #1;
    if (hs_flag) begin
      bus.pll_lock_i  = 1'b0;
      lock_cnt        = LOCK_DLY;
      stall_cnt       = 0;
      bus.cfg_ready_i = !stall_mode;
    end else begin
      if (!lock_auto) bus.pll_lock_i = 1'b0;
      else if (lock_cnt > 0) begin
        lock_cnt--;
        if (lock_cnt == 0) bus.pll_lock_i = 1'b1;
      end
      if (!stall_mode) bus.cfg_ready_i = 1'b1;
      else if (!bus.cfg_valid_o) bus.cfg_ready_i = 1'b0;
      else if (!bus.cfg_ready_i) begin
        stall_cnt++;
        if (stall_cnt > STALL) bus.cfg_ready_i = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear();
    words_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_req(input logic [11:0] cur_fb, input logic [31:0] tgt, input logic [31:0] first);
    bus.cur_cfg_i   = {4'h0, cur_fb, 16'h0055};
    bus.req_cfg_i   = tgt;
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    bus.cur_cfg_i   = 32'hFFFF_FFFF;
    chk("first_valid", 32'(bus.cfg_valid_o), 32'd1);
    chk("first_word", bus.cfg_o, first);
    chk("first_ready_low", 32'(bus.req_ready_o), 32'd0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!bus.req_ready_o && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.req_ready_o), 32'd1);
  endtask

  task automatic wait_words(input int cnt, input int budget, input string tag);
    int n = 0;
    while (words_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(words_q.size()), 32'(cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.cfg_valid_o), 32'd0);
    chk({tag, "_cfg"}, bus.cfg_o, 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
    chk({tag, "_step"}, 32'(bus.step_cnt_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int n;
    rst             = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_cfg_i   = '0;
    bus.cur_cfg_i   = '0;
    bus.abort_i     = 1'b0;
    bus.cfg_ready_i = 1'b1;
    bus.pll_lock_i  = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Up-ramp 100 -> 120: 108, 116, 120
    clear();
    start_req(12'd100, UP_TGT, {4'hA, 12'd108, 16'h1234});
    wait_idle(300, "up_idle");
    chk("up_words", 32'(words_q.size()), 32'd3);
    chk("up_w0", words_q[0], {4'hA, 12'd108, 16'h1234});
    chk("up_w1", words_q[1], {4'hA, 12'd116, 16'h1234});
    chk("up_w2", words_q[2], UP_TGT);
    chk("up_step", 32'(bus.step_cnt_o), 32'd3);
    chk("up_done", 32'(done_cnt), 32'd1);
    chk("up_err", 32'(bus.err_o), 32'd0);

    // Equal target: single word equal to the request
    clear();
    start_req(12'd64, EQ_TGT, EQ_TGT);
    wait_idle(300, "eq_idle");
    chk("eq_words", 32'(words_q.size()), 32'd1);
    chk("eq_w0", words_q[0], EQ_TGT);
    chk("eq_done", 32'(done_cnt), 32'd1);
    chk("eq_step", 32'(bus.step_cnt_o), 32'd1);

    // Down-ramp 50 -> 40 with backpressure: 42, 40
    clear();
    stall_mode = 1;
    tick();
    start_req(12'd50, DN_TGT, {4'h3, 12'd42, 16'h0F21});
    wait_idle(400, "dn_idle");
    chk("dn_words", 32'(words_q.size()), 32'd2);
    chk("dn_w0", words_q[0], {4'h3, 12'd42, 16'h0F21});
    chk("dn_w1", words_q[1], DN_TGT);
    chk("dn_done", 32'(done_cnt), 32'd1);
    chk("dn_step", 32'(bus.step_cnt_o), 32'd2);
    stall_mode = 0;

    // Lock timeout: ERROR in cycle M+21, err_o from M+22
    clear();
    lock_auto = 0;
    repeat (3) tick();
    start_req(12'd100, TO_TGT, {4'h7, 12'd108, 16'h4411});
    wait_words(1, 50, "to_first_hs");
    target = hs_cyc + 21;
    n = 0;
    while (cyc < target && n < 100) begin
      tick();
      n++;
    end
    chk("to_err_pre", 32'(bus.err_o), 32'd0);
    chk("to_busy_in_error", 32'(bus.busy_o), 32'd1);
    tick();
    chk("to_err", 32'(bus.err_o), 32'd1);
    chk("to_ready", 32'(bus.req_ready_o), 32'd1);
    repeat (30) tick();
    chk("to_words", 32'(words_q.size()), 32'd1);
    chk("to_done", 32'(done_cnt), 32'd0);
    chk("to_step", 32'(bus.step_cnt_o), 32'd1);
    chk("to_err_sticky", 32'(bus.err_o), 32'd1);

    // Abort during SETTLE
    clear();
    lock_auto = 1;
    start_req(12'd100, TO_TGT, {4'h7, 12'd108, 16'h4411});
    chk("ab_err_cleared", 32'(bus.err_o), 32'd0);
    wait_words(1, 50, "ab_first_hs");
    tick();
    chk("ab_in_settle", 32'(bus.busy_o), 32'd1);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("ab_ready", 32'(bus.req_ready_o), 32'd1);
    chk("ab_busy", 32'(bus.busy_o), 32'd0);
    repeat (30) tick();
    chk("ab_words", 32'(words_q.size()), 32'd1);
    chk("ab_done", 32'(done_cnt), 32'd0);
    chk("ab_step", 32'(bus.step_cnt_o), 32'd1);

    // Abort during ISSUE with ready low: word still goes out, then IDLE
    clear();
    stall_mode = 1;
    tick();
    start_req(12'd100, TO_TGT, {4'h7, 12'd108, 16'h4411});
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("ai_valid_held", 32'(bus.cfg_valid_o), 32'd1);
    wait_words(1, 50, "ai_hs");
    tick();
    chk("ai_ready", 32'(bus.req_ready_o), 32'd1);
    chk("ai_valid", 32'(bus.cfg_valid_o), 32'd0);
    repeat (20) tick();
    chk("ai_words", 32'(words_q.size()), 32'd1);
    chk("ai_w0", words_q[0], {4'h7, 12'd108, 16'h4411});
    chk("ai_done", 32'(done_cnt), 32'd0);
    stall_mode = 0;

    // Asynchronous reset in WAIT_LOCK, then a fresh ramp 300 -> 290
    clear();
    lock_auto = 0;
    tick();
    start_req(12'd100, TO_TGT, {4'h7, 12'd108, 16'h4411});
    wait_words(1, 50, "rs_hs");
    repeat (7) tick();
    chk("rs_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rs_async");
    tick();
    rst = 1'b0;
    lock_auto = 1;
    clear();
    tick();
    start_req(12'd300, RS_TGT, {4'h9, 12'd292, 16'h6C35});
    wait_idle(300, "rs_idle");
    chk("rs_words", 32'(words_q.size()), 32'd2);
    chk("rs_w1", words_q[1], RS_TGT);
    chk("rs_done", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pll_ramp_sequencer.md
# pll_ramp_sequencer

Sequencer that moves the PLL feedback divider from its current value to a requested target in bounded steps, rather than in one jump. Each step is issued as a full 32-bit PLL config word on a valid/ready channel that feeds one requester port of the PLL config arbiter. Before the next step is issued, the block waits a fixed settle time and then waits for PLL lock. It sits in the nominal voltage region beside the PLL controller and is driven by SoC software through a request handshake.

## Interface
Parameters:
- STEP, default 8: FBDIV increment/decrement per step. Legal range 1..4095; 0 is an elaboration error.
- SETTLE_CYCLES, default 256: cycles after each issued word during which lock is ignored. Legal minimum 1.
- LOCK_TIMEOUT, default 4096: maximum cycles spent waiting for lock after settle.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  ramp request valid.
- req_ready_o  out  1  high only in IDLE.
- req_cfg_i  in  32  target config word. Field layout: FBDIV [27:16], REFDIV [13:8], POSTDIV2 [6:4], POSTDIV1 [2:0], control bits [31:28].
- cur_cfg_i  in  32  current applied config from the PLL controller; sampled at accept.
- abort_i  in  1  cancel the ramp in progress.
- cfg_o  out  32  config word to the arbiter.
- cfg_valid_o  out  1  cfg_o valid.
- cfg_ready_i  in  1  arbiter accepts cfg_o.
- pll_lock_i  in  1  PLL LOCK; asynchronous to clk.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse when the ramp completes.
- err_o  out  1  sticky lock-timeout flag.
- step_cnt_o  out  8  words handshaken in the current ramp; saturates at 255.

## Operation
States: IDLE, ISSUE, SETTLE, WAIT_LOCK, DONE, ERROR.

- **Reset values:** state=IDLE, cfg_o=0, cfg_valid_o=0, busy_o=0, done_o=0, err_o=0, step_cnt_o=0, synchronizer=0. req_ready_o=1 because it decodes IDLE.
- **Lock synchronizer:** pll_lock_i passes through a 2-flop synchronizer; only the synchronized value is used.
- **IDLE:**
  - Accept when req_valid_i & req_ready_o.
  - Capture tgt=req_cfg_i and cur=cur_cfg_i[27:16].
  - Clear err_o and step_cnt_o.
  - Compute the first word, then go to ISSUE.
- **Step rule (12-bit unsigned):**
  - If tgt.FBDIV > cur: nxt = (tgt.FBDIV − cur > STEP) ? cur+STEP : tgt.FBDIV.
  - If tgt.FBDIV < cur: symmetric, nxt = cur−STEP or tgt.FBDIV.
  - If equal: nxt = tgt.FBDIV, and exactly one word is issued.
  - Clamping to the target means no wrap-around can occur.
- **Word format:** cfg_o = {tgt[31:28], nxt, tgt[15:0]}. The final word equals req_cfg_i exactly.
- **ISSUE:**
  - cfg_valid_o=1; cfg_o is held stable until cfg_valid_o & cfg_ready_i.
  - cfg_valid_o is never withdrawn before the handshake, including when abort_i is asserted.
  - On handshake: cur←nxt, step_cnt_o++, go to SETTLE.
  - If abort_i is seen during ISSUE, it is latched; after the handshake the block goes to IDLE instead of SETTLE.
- **SETTLE:** count SETTLE_CYCLES cycles, then go to WAIT_LOCK.
- **WAIT_LOCK:**
  - If synchronized lock = 1 and cur == tgt.FBDIV: go to DONE.
  - If synchronized lock = 1 and cur ≠ tgt.FBDIV: compute the next word and go to ISSUE.
  - If LOCK_TIMEOUT cycles elapse without lock: go to ERROR.
- **DONE:** done_o=1 for one cycle, then IDLE.
- **ERROR:** set err_o, then IDLE. The ramp stops at the last issued word; no rollback word is sent.
- **abort_i in SETTLE or WAIT_LOCK:** go to IDLE next cycle. No done_o, err_o unchanged, no further words.
- **Simultaneous lock and abort in WAIT_LOCK:** abort wins.
- **Simultaneous lock and timeout expiry:** lock wins.
- **Reset mid-operation:** all outputs return to their reset values immediately and asynchronously. A partially applied ramp is left as-is.

## Timing
- Accept at cycle N: cfg_valid_o=1 and cfg_o valid at N+1.
- Handshake at cycle M: SETTLE occupies M+1 .. M+SETTLE_CYCLES; WAIT_LOCK begins at M+SETTLE_CYCLES+1.
- Lock latency: pll_lock_i rising is visible internally 2 cycles later.
- Synchronized lock observed in WAIT_LOCK at cycle K:
  - Next word valid at K+1, or
  - done_o high at K+1 and req_ready_o high at K+2.
- Timeout: ERROR occupies the cycle after the LOCK_TIMEOUT-th WAIT_LOCK cycle; err_o is high from the following cycle.
- Back-to-back requests: a new request can be accepted on the first IDLE cycle.
- Outputs: all registered except req_ready_o and busy_o, which decode state.

## Test plan
- **Up-ramp:** cur FBDIV=100, tgt=120, STEP=8, ready=1, lock 10 cycles after each word -> words with FBDIV 108, 116, 120; step_cnt_o=3; one done_o pulse; err_o=0.
- **Down-ramp with backpressure:** cur=50, tgt=40, cfg_ready_i low 5 cycles per word -> cfg_o stable with valid held high; words 42, 40; done_o once.
- **Equal target:** cur=tgt=64, non-FBDIV fields changed -> exactly one word, equal to req_cfg_i; done_o pulse.
- **Timeout:** lock held at 0, SETTLE_CYCLES=4, LOCK_TIMEOUT=16, cur=100, tgt=200 -> one word (108); err_o set 21 cycles after the handshake; req_ready_o back to 1; no second word.
- **Abort:**
  - abort_i in SETTLE -> IDLE next cycle, no done_o, no further words.
  - abort_i in ISSUE with ready low -> valid held until the handshake, then IDLE.
- **Async reset mid-WAIT_LOCK:** rst high -> all outputs return to reset values in the same cycle without a clock edge; a new request after release ramps starting from the sampled cur_cfg_i.
